irq_sequencer: RTL



---
 rtl/irq_sequencer_if.sv | 29 ++
 rtl/irq_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/irq_sequencer_if.sv
// Bus between the CPU/interrupt controller and irq_sequencer.
// The master modport drives the controller and pipeline inputs; the slave modport is the sequencer side.
interface irq_sequencer_if #(
   parameter int unsigned PC_W = 8
) ();
   logic            i_pending;
   logic [PC_W-1:0] vector;
   logic [1:0]      irq_id;
   logic            instr_done;
   logic [PC_W-1:0] pc_cur;
   logic            reti;
   logic            irq_enable;
   logic            pc_load;
   logic [PC_W-1:0] pc_next;
   logic [3:0]      ack;
   logic            stall;
   logic            in_service;
   logic [2:0]      depth;

   modport master (
      output i_pending, vector, irq_id, instr_done, pc_cur, reti,
      input  irq_enable, pc_load, pc_next, ack, stall, in_service, depth
   );

   modport slave (
      input  i_pending, vector, irq_id, instr_done, pc_cur, reti,
      output irq_enable, pc_load, pc_next, ack, stall, in_service, depth
   );
endinterface

// File: rtl/irq_sequencer.sv
// CPU-side interrupt entry/return sequencer with a return-address stack.
// NESTED_IRQ_EN enables priority-based nesting up to DEPTH levels; otherwise a single level is supported.
module irq_sequencer #(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic            clk,
   input logic            clr,
   irq_sequencer_if.slave bus
);
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [1:0]      id;
   } ret_entry_t;

   typedef enum logic [1:0] {S_RUN, S_ENTER, S_SERVICE, S_RETURN} state_t;

   state_t          r_state;
   logic [2:0]      r_depth;
   logic            r_pc_load;
   logic [PC_W-1:0] r_pc_next;
   logic [3:0]      r_ack;
   logic            r_stall;

   ret_entry_t      w_top;
   ret_entry_t      w_new;
   logic            w_ret;
   logic            w_take_nested;
   logic            w_push;

`ifdef NESTED_IRQ_EN
   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0]  MAX_DEPTH = 3'(DEPTH);

   ret_entry_t r_stack [DEPTH];

   assign w_top = r_stack[IDX_W'(r_depth - 3'd1)];
   // Only a strictly higher-priority source may preempt the running ISR.
   assign w_take_nested = bus.instr_done && bus.i_pending && !w_ret &&
                          (r_depth < MAX_DEPTH) && (bus.irq_id > w_top.id);
`else
   localparam logic [2:0]  MAX_DEPTH = (DEPTH != 0) ? 3'd1 : 3'd0;

   ret_entry_t r_stack;

   assign w_top         = r_stack;
   assign w_take_nested = 1'b0;
`endif

   assign w_ret  = bus.instr_done && bus.reti;
   assign w_new  = '{pc: bus.pc_cur, id: bus.irq_id};
   assign w_push = ((r_state == S_RUN) && bus.instr_done && bus.i_pending) ||
                   ((r_state == S_SERVICE) && w_take_nested);

   // Sequencer state, registered strobes and depth counter
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state   <= S_RUN;
         r_depth   <= 3'd0;
         r_pc_load <= 1'b0;
         r_pc_next <= '0;
         r_ack     <= 4'd0;
         r_stall   <= 1'b0;
      end else begin
         r_pc_load <= 1'b0;
         r_ack     <= 4'd0;
         r_stall   <= 1'b0;
         if (w_push) begin
            r_state   <= S_ENTER;
            r_depth   <= 3'(r_depth + 3'd1);
            r_pc_load <= 1'b1;
            r_pc_next <= bus.vector;
            r_ack     <= 4'(4'b0001 << bus.irq_id);
            r_stall   <= 1'b1;
         end else begin
            case (r_state)
               S_ENTER:   r_state <= S_SERVICE;
               S_SERVICE: begin
                  if (w_ret) begin
                     r_state   <= S_RETURN;
                     r_depth   <= 3'(r_depth - 3'd1);
                     r_pc_load <= 1'b1;
                     r_pc_next <= w_top.pc;
                     r_stall   <= 1'b1;
                  end
               end
               // r_depth already reflects the pop performed on entry to RETURN
               S_RETURN:  r_state <= (r_depth == 3'd0) ? S_RUN : S_SERVICE;
               default:   r_state <= S_RUN;
            endcase
         end
      end
   end

   // Return-address storage
`ifdef NESTED_IRQ_EN
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < int'(DEPTH); i++) r_stack[i] <= '0;
      end else if (w_push) begin
         r_stack[IDX_W'(r_depth)] <= w_new;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (clr)         r_stack <= '0;
      else if (w_push) r_stack <= w_new;
   end
`endif

   assign bus.irq_enable = (r_state == S_RUN) ||
                           ((r_state == S_SERVICE) && (r_depth < MAX_DEPTH));
   assign bus.in_service = (r_depth != 3'd0);
   assign bus.depth      = r_depth;
   assign bus.pc_load    = r_pc_load;
   assign bus.pc_next    = r_pc_next;
   assign bus.ack        = r_ack;
   assign bus.stall      = r_stall;
endmodule
